relogio_set_ctrl: RTL and testbench

//  Time-setting controller for the HH:MM:SS clock datapath. It pauses counting and lets
//  the user edit hours, then minutes, with two buttons (mode, inc). On commit it issues a
//  one-cycle parallel load with the edited values, and seconds are cleared to 00.

---
 rtl/relogio_set_ctrl.sv | 153 +++++++++++++++
 tb/tb_relogio_set_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/relogio_set_ctrl.sv
// Time-setting controller for the HH:MM:SS clock: pauses counting, edits hour then minute
// from mode/inc buttons (with hold auto-repeat), and commits via a one-cycle parallel load.
module relogio_set_ctrl #(
  parameter int HOLD_TICKS    = 5,
  parameter int REPEAT_TICKS  = 2,
  parameter int BLINK_TICKS   = 5,
  parameter int TIMEOUT_TICKS = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic       run_enable,
  output logic       load,
  output logic [4:0] load_hour,
  output logic [5:0] load_min,
  output logic       set_active,
  output logic       blink_h,
  output logic       blink_m,
  output logic [4:0] disp_hour,
  output logic [5:0] disp_min
);

  localparam int HOLD_W  = $clog2(HOLD_TICKS + REPEAT_TICKS + 1);
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [HOLD_W-1:0]  HOLD_BASE  = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0]  HOLD_WRAP  = HOLD_W'(HOLD_TICKS + REPEAT_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {RUN, SET_H, SET_M, COMMIT} state_t;

  state_t             state_q, state_d;
  logic               btn_mode_q, btn_inc_q;
  logic [4:0]         shadow_h_q, shadow_h_d;
  logic [5:0]         shadow_m_q, shadow_m_d;
  logic [4:0]         load_hour_q, load_hour_d;
  logic [5:0]         load_min_q, load_min_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;

  logic mode_press, inc_press, in_set, next_in_set, timeout, repeat_hit, inc_event;

  assign mode_press  = btn_mode & ~btn_mode_q;
  assign inc_press   = btn_inc & ~btn_inc_q;
  assign in_set      = (state_q == SET_H) || (state_q == SET_M);
  assign next_in_set = (state_d == SET_H) || (state_d == SET_M);
  // A fresh press restarts the idle window, so it also cancels a coincident timeout.
  assign timeout     = in_set & tick & ~mode_press & ~inc_press & (idle_cnt_q == IDLE_LAST);
  assign repeat_hit  = tick & btn_inc & (hold_cnt_q == HOLD_WRAP);
  assign inc_event   = in_set & ~mode_press & ~timeout & (inc_press | repeat_hit);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      btn_mode_q  <= 1'b0;
      btn_inc_q   <= 1'b0;
      shadow_h_q  <= '0;
      shadow_m_q  <= '0;
      load_hour_q <= '0;
      load_min_q  <= '0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      btn_mode_q  <= btn_mode;
      btn_inc_q   <= btn_inc;
      shadow_h_q  <= shadow_h_d;
      shadow_m_q  <= shadow_m_d;
      load_hour_q <= load_hour_d;
      load_min_q  <= load_min_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mode_press) state_d = SET_H;
      SET_H:   if (mode_press) state_d = SET_M;  else if (timeout) state_d = RUN;
      SET_M:   if (mode_press) state_d = COMMIT; else if (timeout) state_d = RUN;
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    shadow_h_d  = shadow_h_q;
    shadow_m_d  = shadow_m_q;
    load_hour_d = load_hour_q;
    load_min_d  = load_min_q;
    hold_cnt_d  = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    idle_cnt_d  = idle_cnt_q;

    if (state_q == RUN && mode_press) begin
      shadow_h_d = cur_hour;
      shadow_m_d = cur_min;
    end else if (inc_event && state_q == SET_H) begin
      shadow_h_d = (shadow_h_q == 5'd23) ? 5'd0 : shadow_h_q + 5'd1;
    end else if (inc_event && state_q == SET_M) begin
      shadow_m_d = (shadow_m_q == 6'd59) ? 6'd0 : shadow_m_q + 6'd1;
    end

    // Latched on the way into COMMIT so the values stay put until the next commit.
    if (state_q == SET_M && mode_press) begin
      load_hour_d = shadow_h_q;
      load_min_d  = shadow_m_q;
    end

    if (!in_set || state_d != state_q || !btn_inc) hold_cnt_d = '0;
    else if (tick) hold_cnt_d = (hold_cnt_q == HOLD_WRAP) ? HOLD_BASE : hold_cnt_q + 1'b1;

    if (state_d != state_q && next_in_set) begin
      phase_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (!next_in_set || inc_event) begin
      phase_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (tick) begin
      phase_d     = (blink_cnt_q == BLINK_LAST) ? ~phase_q : phase_q;
      blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
    end

    if (mode_press || inc_press || !next_in_set) idle_cnt_d = '0;
    else if (tick) idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_comb begin
    run_enable = (state_q == RUN);
    load       = (state_q == COMMIT);
    load_hour  = load_hour_q;
    load_min   = load_min_q;
    set_active = in_set;
    blink_h    = (state_q == SET_H) & phase_q;
    blink_m    = (state_q == SET_M) & phase_q;
    disp_hour  = in_set ? shadow_h_q : cur_hour;
    disp_min   = in_set ? shadow_m_q : cur_min;
  end

endmodule

// File: tb/tb_relogio_set_ctrl.sv
// Bench for relogio_set_ctrl: directed scenarios with literal expectations plus random
// stimulus, all outputs compared every cycle against a tick-counting behavioural model.
module tb_relogio_set_ctrl;
  localparam int HOLD = 5, REPEAT = 2, BLINK = 5, TIMEOUT = 100;

  logic       clock = 1'b0, reset = 1'b1, tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0;
  logic       run_enable, load, set_active, blink_h, blink_m;
  logic [4:0] load_hour, disp_hour;
  logic [5:0] load_min, disp_min;

  int n_tests = 0, n_fail = 0, load_seen = 0;
  bit chk_en = 1'b0;

  relogio_set_ctrl dut (
    .clock(clock), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hour(cur_hour), .cur_min(cur_min), .run_enable(run_enable), .load(load),
    .load_hour(load_hour), .load_min(load_min), .set_active(set_active),
    .blink_h(blink_h), .blink_m(blink_m), .disp_hour(disp_hour), .disp_min(disp_min)
  );

  always #5 clock = ~clock;

  // Model: 0=RUN 1=SET_H 2=SET_M 3=COMMIT; timers kept as plain tick tallies.
  int m_state, m_sh, m_sm, m_lh, m_lm, m_hold, m_blink, m_base, m_idle;
  bit m_mode_prev, m_inc_prev;

  always @(posedge clock) begin : model
    int nxt;
    bit mp, ip, rep, do_inc;
    if (reset) begin
      m_state = 0; m_sh = 0; m_sm = 0; m_lh = 0; m_lm = 0;
      m_hold = 0; m_blink = 0; m_base = 0; m_idle = 0;
      m_mode_prev = 0; m_inc_prev = 0;
    end else begin
      mp = btn_mode && !m_mode_prev;
      ip = btn_inc && !m_inc_prev;
      m_mode_prev = btn_mode;
      m_inc_prev = btn_inc;
      nxt = m_state;
      if (m_state == 0) begin
        if (mp) begin nxt = 1; m_sh = cur_hour; m_sm = cur_min; end
      end else if (m_state == 3) begin
        nxt = 0;
      end else begin
        if (mp || ip) m_idle = 0; else if (tick) m_idle++;
        if (mp) begin
          nxt = m_state + 1;
          if (m_state == 2) begin m_lh = m_sh; m_lm = m_sm; end
        end else if (m_idle >= TIMEOUT) begin
          nxt = 0;
        end else begin
          if (btn_inc) begin if (tick) m_hold++; end else m_hold = 0;
          rep = tick && btn_inc && m_hold > HOLD && ((m_hold - HOLD) % REPEAT) == 0;
          do_inc = ip || rep;
          if (do_inc) begin
            if (m_state == 1) m_sh = (m_sh + 1) % 24; else m_sm = (m_sm + 1) % 60;
            m_blink = 0; m_base = 0;
          end else if (tick) m_blink++;
        end
      end
      if (nxt != m_state) begin
        m_hold = 0; m_blink = 0; m_base = 1; m_idle = 0; m_state = nxt;
      end
    end
  end

  always @(negedge clock) begin : compare
    logic [26:0] got, exp;
    bit act, ph;
    if (chk_en) begin
      act = (m_state == 1) || (m_state == 2);
      ph  = m_base[0] ^ ((m_blink / BLINK) % 2 == 1);
      exp = {m_state == 0, m_state == 3, 5'(m_lh), 6'(m_lm), act,
             (m_state == 1) && ph, (m_state == 2) && ph,
             act ? 5'(m_sh) : cur_hour, act ? 6'(m_sm) : cur_min};
      got = {run_enable, load, load_hour, load_min, set_active, blink_h, blink_m,
             disp_hour, disp_min};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, got, exp);
      end
      if (load) load_seen++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1; btn_mode = 0; btn_inc = 0; tick = 0;
    step(2);
    reset = 0;
    step(1);
    load_seen = 0;
  endtask

  task automatic press_mode();
    btn_mode = 1; step(1); btn_mode = 0; step(1);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1; step(1); btn_inc = 0; step(1);
    end
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1; step(1); tick = 0; step(1);
    end
  endtask

  initial begin
    step(3);
    chk_en = 1;
    do_reset();
    check("reset_run_enable", run_enable, 1);
    check("reset_load_hour", load_hour, 0);

    // Commit path: 10:20 -> 13:05
    cur_hour = 10; cur_min = 20;
    press_mode();
    press_inc(3);
    press_mode();
    press_inc(45);
    btn_mode = 1; step(1);
    check("commit_load_pulse", load, 1);
    check("commit_run_enable_low", run_enable, 0);
    btn_mode = 0; step(1);
    check("commit_load_hour", load_hour, 13);
    check("commit_load_min", load_min, 5);
    check("commit_run_enable", run_enable, 1);
    check("model_load_hour", m_lh, 13);
    check("model_load_min", m_lm, 5);
    step(3);
    check("commit_load_count", load_seen, 1);

    // Reset mid-SET_M discards the edit
    load_seen = 0;
    press_mode(); press_mode(); press_inc(2);
    reset = 1; step(3); reset = 0; step(1);
    check("midreset_run_enable", run_enable, 1);
    check("midreset_set_active", set_active, 0);
    check("midreset_load_hour", load_hour, 0);
    check("midreset_no_load", load_seen, 0);

    // Wrap boundaries
    cur_hour = 23; cur_min = 59;
    press_mode(); press_inc(1);
    check("wrap_hour", disp_hour, 0);
    press_mode(); press_inc(1);
    check("wrap_min", disp_min, 0);
    check("model_wrap_min", m_sm, 0);

    // Auto-repeat: 1 press + 4 repeats over 13 held ticks
    do_reset();
    cur_hour = 0; cur_min = 0;
    press_mode(); press_mode();
    btn_inc = 1; step(1);
    pulse_ticks(HOLD + REPEAT * 4);
    check("repeat_min", disp_min, 5);
    check("model_repeat_min", m_sm, 5);
    btn_inc = 0; step(1);

    // Mode and inc together in SET_H: mode wins
    do_reset();
    cur_hour = 7; cur_min = 30;
    press_mode();
    btn_mode = 1; btn_inc = 1; step(1);
    btn_mode = 0; btn_inc = 0; step(1);
    check("tie_blink_m", blink_m, 1);
    check("tie_blink_h", blink_h, 0);
    check("tie_shadow_h", disp_hour, 7);

    // Timeout abort after 100 idle ticks
    do_reset();
    press_mode();
    pulse_ticks(TIMEOUT - 1);
    check("timeout_99_still_set", set_active, 1);
    tick = 1; step(1); tick = 0;
    check("timeout_run_enable", run_enable, 1);
    check("timeout_set_active", set_active, 0);
    step(2);
    check("timeout_no_load", load_seen, 0);

    // Random soak against the model
    for (int i = 0; i < 4000; i++) begin
      tick     = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 39) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 7) == 0) btn_inc = ~btn_inc;
      if ($urandom_range(0, 9) == 0) begin
        cur_hour = 5'($urandom_range(0, 23));
        cur_min  = 6'($urandom_range(0, 59));
      end
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
